// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: INFO word, CTRL read/write words, STAT read-only words and an
// optional W1C interrupt controller that is compiled in when AXIL_CSR_BANK_IRQ_EN is defined.
module axil_csr_bank #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 12,
  parameter int              CTRL       = 4,
  parameter int              STAT       = 4,
  parameter int              INTERRUPTS = 1,
  parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_W-1:0]            awAddr,
  input  logic [2:0]                   awProt,
  input  logic                         awValid,
  output logic                         awReady,
  input  logic [DATA_W-1:0]            wData,
  input  logic [DATA_W/8-1:0]          wStrb,
  input  logic                         wValid,
  output logic                         wReady,
  output logic [1:0]                   bResp,
  output logic                         bValid,
  input  logic                         bReady,
  input  logic [ADDR_W-1:0]            arAddr,
  input  logic [2:0]                   arProt,
  input  logic                         arValid,
  output logic                         arReady,
  output logic [DATA_W-1:0]            rData,
  output logic [1:0]                   rResp,
  output logic                         rValid,
  input  logic                         rReady,
  output logic [CTRL-1:0][DATA_W-1:0]  ctrl,
  output logic [CTRL-1:0]              ctrlWr,
  input  logic [STAT-1:0][DATA_W-1:0]  stat,
  input  logic [INTERRUPTS-1:0]        interrupts,
  output logic                         irq
);

  localparam int SB      = DATA_W / 8;
  localparam int LSB     = (DATA_W == 64) ? 3 : 2;
  localparam int IDX_W   = ADDR_W - LSB;
  localparam int CTRL_LO = 4;
  localparam int STAT_LO = 4 + CTRL;
  localparam int MAP_END = 4 + CTRL + STAT;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_CSR_BANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic                        r_live;
  logic                        r_aw_held;
  logic                        r_w_held;
  logic [IDX_W-1:0]            r_aw_idx;
  logic [DATA_W-1:0]           r_w_data;
  logic [SB-1:0]               r_w_strb;
  logic                        r_bvalid;
  logic [1:0]                  r_bresp;
  logic                        r_rvalid;
  logic [1:0]                  r_rresp;
  logic [DATA_W-1:0]           r_rdata;
  logic [CTRL-1:0][DATA_W-1:0] r_ctrl;
  logic [CTRL-1:0]             r_ctrl_wr;

  logic                        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_is_ctrl;
  logic [IDX_W-1:0]            w_widx;
  logic [31:0]                 w_wword, w_rword;
  logic [DATA_W-1:0]           w_wdata, w_bmask, w_info, w_rd_data;
  logic [SB-1:0]               w_wstrb;
  logic [1:0]                  w_rd_resp;
  logic [INTERRUPTS-1:0]       w_pend, w_en;
  logic                        w_unused;

  // r_live keeps every ready low while reset is held and for the reset cycle itself.
  assign awReady = r_live && !r_aw_held && !r_bvalid;
  assign wReady  = r_live && !r_w_held && !r_bvalid;
  assign arReady = r_live && (!r_rvalid || rReady);
  assign w_aw_hs = awValid && awReady;
  assign w_w_hs  = wValid && wReady;
  assign w_ar_hs = arValid && arReady;

  // A write commits in the cycle its second half arrives, held or live.
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_widx   = r_aw_held ? r_aw_idx : awAddr[ADDR_W-1:LSB];
  assign w_wdata  = r_w_held ? r_w_data : wData;
  assign w_wstrb  = r_w_held ? r_w_strb : wStrb;
  assign w_wword  = 32'(w_widx);
  assign w_rword  = 32'(arAddr[ADDR_W-1:LSB]);

  assign w_is_ctrl = (w_wword >= CTRL_LO) && (w_wword < STAT_LO);
  assign w_wr_ok   = w_is_ctrl || (IRQ_ON && (w_wword == 32'd1 || w_wword == 32'd2));

  // NOTE: every always_comb assigns its outputs a default first so no path can infer a latch.
  always_comb begin
    w_bmask = '0;
    for (int k = 0; k < SB; k++) w_bmask[8*k +: 8] = {8{w_wstrb[k]}};
  end

  always_comb begin
    w_info        = '0;
    w_info[7:0]   = 8'(CTRL);
    w_info[15:8]  = 8'(STAT);
    w_info[23:16] = 8'(INTERRUPTS);
    w_info[24]    = IRQ_ON;
    w_info[25]    = (DATA_W == 64);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_ctrl    <= {CTRL{CTRL_RST}};
      r_ctrl_wr <= '0;
    end else begin
      r_live    <= 1'b1;
      r_ctrl_wr <= '0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < CTRL; i++) begin
          if (w_is_ctrl && w_wword == 32'(CTRL_LO + i)) begin
            r_ctrl[i]    <= (r_ctrl[i] & ~w_bmask) | (w_wdata & w_bmask);
            r_ctrl_wr[i] <= 1'b1;
          end
        end
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
        if (r_bvalid && bReady) r_bvalid <= 1'b0;
      end
    end
  end

  // NOTE: the holding payload is not reset; it is only ever consumed while its held flag is set.
  always_ff @(posedge aclk) begin
    if (w_aw_hs) r_aw_idx <= awAddr[ADDR_W-1:LSB];
    if (w_w_hs) begin
      r_w_data <= wData;
      r_w_strb <= wStrb;
    end
  end

`ifdef AXIL_CSR_BANK_IRQ_EN
  logic [INTERRUPTS-1:0] r_pend, r_en, w_pend_clr, w_imask;
  logic                  r_irq;

  assign w_imask    = w_bmask[INTERRUPTS-1:0];
  assign w_pend_clr = (w_commit && w_wword == 32'd1) ? (w_wdata[INTERRUPTS-1:0] & w_imask) : '0;

  // A source that is high in the clearing cycle keeps its pending bit set.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pend <= '0;
      r_en   <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | interrupts;
      if (w_commit && w_wword == 32'd2) r_en <= (r_en & ~w_imask) | (w_wdata[INTERRUPTS-1:0] & w_imask);
      r_irq  <= |(r_pend & r_en);
    end
  end

  assign w_pend   = r_pend;
  assign w_en     = r_en;
  assign irq      = r_irq;
  assign w_unused = ^{awProt, arProt, awAddr[LSB-1:0], arAddr[LSB-1:0]};
`else
  assign w_pend   = '0;
  assign w_en     = '0;
  assign irq      = 1'b0;
  assign w_unused = ^{awProt, arProt, awAddr[LSB-1:0], arAddr[LSB-1:0], interrupts};
`endif

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    if (w_rword == 32'd0) begin
      w_rd_data = w_info;
      w_rd_resp = RESP_OKAY;
    end else if (IRQ_ON && w_rword == 32'd1) begin
      w_rd_data = DATA_W'(w_pend);
      w_rd_resp = RESP_OKAY;
    end else if (IRQ_ON && w_rword == 32'd2) begin
      w_rd_data = DATA_W'(w_en);
      w_rd_resp = RESP_OKAY;
    end else if (IRQ_ON && w_rword == 32'd3) begin
      w_rd_data = DATA_W'(interrupts);
      w_rd_resp = RESP_OKAY;
    end else if (w_rword >= CTRL_LO && w_rword < STAT_LO) begin
      w_rd_resp = RESP_OKAY;
      for (int i = 0; i < CTRL; i++)
        if (w_rword == 32'(CTRL_LO + i)) w_rd_data = r_ctrl[i];
    end else if (w_rword >= STAT_LO && w_rword < MAP_END) begin
      w_rd_resp = RESP_OKAY;
      for (int i = 0; i < STAT; i++)
        if (w_rword == 32'(STAT_LO + i)) w_rd_data = stat[i];
    end
  end

  // Read data is captured at the address handshake, so a same-cycle write shows its old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_resp;
      r_rdata  <= w_rd_data;
    end else if (rReady) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bValid = r_bvalid;
  assign bResp  = r_bresp;
  assign rValid = r_rvalid;
  assign rResp  = r_rresp;
  assign rData  = r_rdata;
  assign ctrl   = r_ctrl;
  assign ctrlWr = r_ctrl_wr;

endmodule

// File: tb/tb_axil_csr_bank.sv
// Self-checking bench for axil_csr_bank: a reference model feeds expected responses into
// scoreboard queues at handshake time, which are popped when the DUT responds.
module tb_axil_csr_bank;
  localparam int DATA_W = 32, ADDR_W = 12, CTRL = 4, STAT = 4, INTERRUPTS = 1;
  localparam int SB = DATA_W / 8;
  localparam logic [DATA_W-1:0] CTRL_RST = '0;
`ifdef AXIL_CSR_BANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rsp_t;

  logic aclk = 1'b0;
  logic areset;
  logic [ADDR_W-1:0] awAddr, arAddr;
  logic [2:0] awProt, arProt;
  logic awValid, awReady, wValid, wReady, bValid, bReady, arValid, arReady, rValid, rReady;
  logic [DATA_W-1:0] wData, rData;
  logic [SB-1:0] wStrb;
  logic [1:0] bResp, rResp;
  logic [CTRL-1:0][DATA_W-1:0] ctrl;
  logic [CTRL-1:0] ctrlWr;
  logic [STAT-1:0][DATA_W-1:0] stat;
  logic [INTERRUPTS-1:0] interrupts;
  logic irq;

  always #5 aclk = ~aclk;

  axil_csr_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL(CTRL), .STAT(STAT),
                  .INTERRUPTS(INTERRUPTS), .CTRL_RST(CTRL_RST)) dut (
    .aclk(aclk), .areset(areset),
    .awAddr(awAddr), .awProt(awProt), .awValid(awValid), .awReady(awReady),
    .wData(wData), .wStrb(wStrb), .wValid(wValid), .wReady(wReady),
    .bResp(bResp), .bValid(bValid), .bReady(bReady),
    .arAddr(arAddr), .arProt(arProt), .arValid(arValid), .arReady(arReady),
    .rData(rData), .rResp(rResp), .rValid(rValid), .rReady(rReady),
    .ctrl(ctrl), .ctrlWr(ctrlWr), .stat(stat), .interrupts(interrupts), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] bq[$];
  rsp_t       rq[$];
  logic [DATA_W-1:0]     m_ctrl [CTRL];
  logic [INTERRUPTS-1:0] m_en, m_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CTRL; i++) m_ctrl[i] = CTRL_RST;
    m_en   = '0;
    m_pend = '0;
  endfunction

  function automatic logic [1:0] model_write(input int idx, input logic [DATA_W-1:0] data,
                                             input logic [SB-1:0] strb);
    logic [DATA_W-1:0] m = '0;
    for (int k = 0; k < SB; k++) m[8*k +: 8] = {8{strb[k]}};
    if (idx >= 4 && idx < 4 + CTRL) begin
      m_ctrl[idx-4] = (m_ctrl[idx-4] & ~m) | (data & m);
      return 2'b00;
    end
    if (IRQ_ON && idx == 1) begin
      m_pend = m_pend & ~INTERRUPTS'(data & m);
      return 2'b00;
    end
    if (IRQ_ON && idx == 2) begin
      m_en = (m_en & ~INTERRUPTS'(m)) | INTERRUPTS'(data & m);
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic rsp_t model_read(input int idx);
    rsp_t r;
    r.data = '0;
    r.resp = 2'b00;
    if (idx == 0)                              r.data = IRQ_ON ? 32'h0101_0404 : 32'h0001_0404;
    else if (IRQ_ON && idx == 1)               r.data = DATA_W'(m_pend);
    else if (IRQ_ON && idx == 2)               r.data = DATA_W'(m_en);
    else if (IRQ_ON && idx == 3)               r.data = DATA_W'(interrupts);
    else if (idx >= 4 && idx < 4 + CTRL)       r.data = m_ctrl[idx-4];
    else if (idx >= 4 + CTRL && idx < 4 + CTRL + STAT) r.data = stat[idx-4-CTRL];
    else                                       r.resp = 2'b10;
    return r;
  endfunction

  // Called at posedge+2; consumes one write response and returns at posedge+1.
  task automatic collect_b();
    int n = 0;
    logic [1:0] e;
    bReady = 1'b1;
    while (!bValid && n < 50) begin @(posedge aclk); #2; n++; end
    if (!bValid || bq.size() == 0) check("b_timeout", 64'd0, 64'd1);
    else begin
      e = bq.pop_front();
      check("b_resp", bResp, e);
    end
    @(posedge aclk); #1;
  endtask

  // Called at posedge+1. With wait_b it returns at posedge+1, otherwise at posedge+2 right
  // after the post-commit checks, leaving the response outstanding.
  task automatic axi_write(input int idx, input logic [DATA_W-1:0] data, input logic [SB-1:0] strb,
                           input int aw_dly, input int w_dly, input bit wait_b);
    bit aw_done = 1'b0, w_done = 1'b0;
    int cyc = 0;
    bq.push_back(model_write(idx, data, strb));
    while (!(aw_done && w_done)) begin
      awAddr  = ADDR_W'(idx * SB);
      awValid = !aw_done && cyc >= aw_dly;
      wData   = data;
      wStrb   = strb;
      wValid  = !w_done && cyc >= w_dly;
      #1;
      if (awValid && awReady) aw_done = 1'b1;
      if (wValid && wReady)   w_done  = 1'b1;
      @(posedge aclk); #1;
      cyc++;
      if (cyc > 60) begin check("w_timeout", 64'd0, 64'd1); break; end
    end
    awValid = 1'b0;
    wValid  = 1'b0;
    #1;
    check("b_latency", bValid, 64'd1);
    if (idx >= 4 && idx < 4 + CTRL) begin
      check("ctrl_wr_pulse", ctrlWr, 64'(1 << (idx - 4)));
      check("ctrl_value", ctrl[idx-4], m_ctrl[idx-4]);
    end else begin
      check("ctrl_wr_idle", ctrlWr, 64'd0);
    end
    if (wait_b) begin
      collect_b();
      #1;
      check("ctrl_wr_once", ctrlWr, 64'd0);
      @(posedge aclk); #1;
    end
  endtask

  // Called at posedge+1, returns at posedge+1.
  task automatic axi_read(input int idx);
    int n = 0;
    rsp_t e;
    arAddr  = ADDR_W'(idx * SB);
    arValid = 1'b1;
    rReady  = 1'b1;
    #1;
    while (!arReady && n < 50) begin @(posedge aclk); #2; n++; end
    if (!arReady) check("ar_timeout", 64'd0, 64'd1);
    rq.push_back(model_read(idx));
    @(posedge aclk); #1;
    arValid = 1'b0;
    #1;
    check("r_latency", rValid, 64'd1);
    if (rq.size() == 0) check("r_sb_empty", 64'd0, 64'd1);
    else begin
      e = rq.pop_front();
      check($sformatf("r_data[%0d]", idx), rData, e.data);
      check($sformatf("r_resp[%0d]", idx), rResp, e.resp);
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rsp_t e;
    areset = 1'b1;
    awAddr = '0; awProt = '0; awValid = 1'b0;
    wData = '0; wStrb = '0; wValid = 1'b0; bReady = 1'b1;
    arAddr = '0; arProt = '0; arValid = 1'b0; rReady = 1'b1;
    interrupts = '0;
    for (int i = 0; i < STAT; i++) stat[i] = 32'hA000_0000 | 32'(i * 32'h111);
    model_reset();

    // Reset state
    repeat (3) @(posedge aclk);
    #2;
    check("rst_aw_ready_low", awReady, 64'd0);
    check("rst_ar_ready_low", arReady, 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #2;
    check("rst_aw_ready", awReady, 64'd1);
    check("rst_w_ready", wReady, 64'd1);
    check("rst_ar_ready", arReady, 64'd1);
    check("rst_b_valid", bValid, 64'd0);
    check("rst_r_valid", rValid, 64'd0);
    check("rst_r_data", rData, 64'd0);
    check("rst_ctrl", 64'(ctrl), 64'(CTRL_RST));
    check("rst_ctrl_wr", ctrlWr, 64'd0);
    check("rst_irq", irq, 64'd0);
    @(posedge aclk); #1;

    // INFO word, then a strobed write with data arriving three cycles ahead of the address
    axi_read(0);
    axi_write(4, 32'hDEAD_BEEF, 4'b0101, 3, 0, 1'b1);
    check("strobed_ctrl0", ctrl[0], 64'h00AD_00EF);
    axi_write(5, 32'h1234_5678, 4'hF, 0, 0, 1'b1);
    axi_write(7, 32'hCAFE_F00D, 4'b1010, 0, 2, 1'b1);
    axi_write(6, 32'hFFFF_FFFF, 4'b0000, 1, 1, 1'b1);
    for (int i = 4; i < 4 + CTRL; i++) axi_read(i);
    for (int i = 4 + CTRL; i < 4 + CTRL + STAT; i++) axi_read(i);

    // Read-only and unmapped accesses
    axi_write(0, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b1);
    axi_write(8, 32'h5555_5555, 4'hF, 0, 0, 1'b1);
    axi_write(100, 32'h5555_5555, 4'hF, 0, 0, 1'b1);
    axi_read(0);
    axi_read(200);
    axi_read(4 + CTRL + STAT);

    // Back-pressure on the write response
    bReady = 1'b0;
    axi_write(5, 32'h0BAD_F00D, 4'hF, 0, 0, 1'b0);
    repeat (5) begin
      check("bstall_valid", bValid, 64'd1);
      check("bstall_resp", bResp, 64'd0);
      check("bstall_aw_ready", awReady, 64'd0);
      check("bstall_w_ready", wReady, 64'd0);
      @(posedge aclk); #2;
    end
    collect_b();

    // Back-pressure on the read response
    rReady  = 1'b0;
    arAddr  = ADDR_W'(5 * SB);
    arValid = 1'b1;
    #1;
    n = 0;
    while (!arReady && n < 50) begin @(posedge aclk); #2; n++; end
    rq.push_back(model_read(5));
    @(posedge aclk); #1;
    arValid = 1'b0;
    #1;
    e = rq[0];
    repeat (5) begin
      check("rstall_valid", rValid, 64'd1);
      check("rstall_data", rData, e.data);
      check("rstall_ar_ready", arReady, 64'd0);
      @(posedge aclk); #2;
    end
    rReady = 1'b1;
    e = rq.pop_front();
    check("rstall_final_data", rData, e.data);
    check("rstall_final_resp", rResp, e.resp);
    @(posedge aclk); #1;

`ifdef AXIL_CSR_BANK_IRQ_EN
    axi_write(2, 32'h1, 4'hF, 0, 0, 1'b1);
    interrupts = 1'b1;
    @(posedge aclk); #1;
    interrupts = 1'b0;
    #1;
    check("irq_lag", irq, 64'd0);
    @(posedge aclk); #2;
    check("irq_set", irq, 64'd1);
    m_pend = 1'b1;
    @(posedge aclk); #1;
    axi_read(1);
    interrupts = 1'b1;
    axi_write(1, 32'h1, 4'hF, 0, 0, 1'b1);
    m_pend = 1'b1;
    axi_read(1);
    axi_read(3);
    check("irq_set_wins", irq, 64'd1);
    interrupts = 1'b0;
    @(posedge aclk); #1;
    axi_write(1, 32'h1, 4'hF, 0, 0, 1'b0);
    check("irq_clear_lag", irq, 64'd1);
    collect_b();
    #1;
    check("irq_cleared", irq, 64'd0);
    @(posedge aclk); #1;
    axi_read(1);
    axi_read(2);
`else
    axi_read(1);
    axi_read(2);
    axi_read(3);
    axi_write(2, 32'h1, 4'hF, 0, 0, 1'b1);
    interrupts = 1'b1;
    repeat (3) begin
      @(posedge aclk); #2;
      check("irq_absent", irq, 64'd0);
    end
    interrupts = 1'b0;
    @(posedge aclk); #1;
`endif

    // Reset while an address is held and data is still pending
    awAddr  = ADDR_W'(4 * SB);
    awValid = 1'b1;
    #1;
    n = 0;
    while (!awReady && n < 50) begin @(posedge aclk); #2; n++; end
    @(posedge aclk); #1;
    awValid = 1'b0;
    areset  = 1'b1;
    @(posedge aclk); #2;
    check("mid_rst_aw_ready", awReady, 64'd0);
    check("mid_rst_b_valid", bValid, 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    @(posedge aclk); #2;
    check("post_rst_aw_ready", awReady, 64'd1);
    check("post_rst_w_ready", wReady, 64'd1);
    check("post_rst_ar_ready", arReady, 64'd1);
    check("post_rst_b_valid", bValid, 64'd0);
    check("post_rst_ctrl", 64'(ctrl), 64'(CTRL_RST));
    @(posedge aclk); #1;
    wData  = 32'h7777_1234;
    wStrb  = 4'hF;
    wValid = 1'b1;
    #1;
    n = 0;
    while (!wReady && n < 50) begin @(posedge aclk); #2; n++; end
    @(posedge aclk); #1;
    wValid = 1'b0;
    repeat (3) begin
      @(posedge aclk); #2;
      check("aw_dropped_no_b", bValid, 64'd0);
    end
    bq.push_back(model_write(4, 32'h7777_1234, 4'hF));
    awAddr  = ADDR_W'(4 * SB);
    awValid = 1'b1;
    n = 0;
    while (!awReady && n < 50) begin @(posedge aclk); #2; n++; end
    @(posedge aclk); #1;
    awValid = 1'b0;
    #1;
    check("late_aw_b_valid", bValid, 64'd1);
    collect_b();
    axi_read(4);

    check("sb_drained", 64'(bq.size() + rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
